// File: rtl/demux_pkg.sv
// Shared types for the demux dispatcher: FSM state encoding and the select-width helper
// used by the dispatcher, the downstream demux and the bench.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Select width for an N-way demux; clamped to 1 so degenerate N still yields a legal vector
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/next_set_index.sv
// Priority search: lowest set mask bit strictly above cur, or the lowest set bit
// overall when first is high.
module next_set_index
  import demux_pkg::*;
#(
  parameter int N = 10,
  localparam int SW = sel_w(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [SW-1:0] cur_i,
  input  logic          first_i,
  output logic [SW-1:0] idx_o,
  output logic          found_o
);

  // Scan top-down so the last hit written is the lowest qualifying index
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_i[k] && (first_i || (k > int'(cur_i)))) begin
        idx_o   = SW'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatcher.sv
// Serialises one N-bit word onto a 1-bit demux lane, visiting only the channels
// enabled by the captured mask, in ascending order, with one done pulse per word.
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter int N = 10,
  localparam int SW = sel_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  in_mask,
  input  logic          pause,
  output logic          y,
  output logic [SW-1:0] s,
  output logic          strobe,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [N-1:0]  data_q, data_d, mask_q, mask_d;
  logic [SW-1:0] nxt_idx;
  logic          nxt_found;
  logic          xfer;

  assign in_ready = (state_q != ST_SEND);
  assign xfer     = in_valid && in_ready;

  // One searcher serves both cases: first index of an incoming mask, or the
  // successor of s in the held mask; the two never coincide in time.
  next_set_index #(.N(N)) u_nsi (
    .mask_i  (xfer ? in_mask : mask_q),
    .cur_i   (s_q),
    .first_i (xfer),
    .idx_o   (nxt_idx),
    .found_o (nxt_found)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    data_d  = data_q;
    mask_d  = mask_q;
    case (state_q)
      ST_SEND: begin
        if (!pause) begin
          if (nxt_found) s_d = nxt_idx;
          else           state_d = ST_DONE;
        end
      end
      default: begin
        if (xfer) begin
          data_d  = in_data;
          mask_d  = in_mask;
          s_d     = nxt_found ? nxt_idx : '0;
          state_d = nxt_found ? ST_SEND : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign strobe = (state_q == ST_SEND) && !pause;
  assign y      = strobe && data_q[s_q];
  assign s      = s_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

endmodule
